ldm_stm_sequencer: RTL

//  Multi-cycle sequencer for ARM block transfers (LDM/STM, modes IA/IB/DA/DB).

---
 rtl/ldm_stm_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: multi-cycle LDM/STM block-transfer engine (IA/IB/DA/DB).
// Moves one register per cycle between the register file and data memory,
// lowest register at the lowest address, then optionally writes back the base.
module ldm_stm_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_is_load,
  input  logic              i_up,
  input  logic              i_pre,
  input  logic              i_wback,
  input  logic [3:0]        i_rn,
  input  logic [DATA_W-1:0] i_base,
  input  logic [15:0]       i_reg_list,
  output logic              o_busy,
  output logic              o_done,
  output logic [3:0]        o_ra,
  input  logic [DATA_W-1:0] i_rd,
  output logic [3:0]        o_wa3,
  output logic              o_we3,
  output logic [DATA_W-1:0] o_wd3,
  output logic              o_pc_we,
  output logic [DATA_W-1:0] o_pc_wd,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wd,
  input  logic [DATA_W-1:0] i_mem_rd
);

  localparam logic [DATA_W-1:0] WORD = DATA_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [15:0]         r_list;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_final;
  logic [3:0]          r_rn;
  logic                r_is_load;
  logic                r_wb;

  logic [4:0]          w_cnt;
  logic [DATA_W-1:0]   w_span;
  logic [DATA_W-1:0]   w_first;
  logic [DATA_W-1:0]   w_final;
  logic                w_wb;
  logic [3:0]          w_cur;
  logic                w_last;

  // Transfer count of the incoming list
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < 16; i++) w_cnt = w_cnt + 5'(i_reg_list[i]);
  end

  assign w_span  = DATA_W'(w_cnt) << 2;
  assign w_final = i_up ? i_base + w_span : i_base - w_span;
  // Base writeback is suppressed when a load would also overwrite the base
  assign w_wb    = i_wback && (w_cnt != 5'd0) && (i_rn != 4'd15) &&
                   !(i_is_load && i_reg_list[i_rn]);

  // Lowest address of the block; transfers always walk upward from here
  always_comb begin
    case ({i_up, i_pre})
      2'b10:   w_first = i_base;
      2'b11:   w_first = i_base + WORD;
      2'b00:   w_first = i_base - w_span + WORD;
      default: w_first = i_base - w_span;
    endcase
  end

  // Lowest pending register, and whether it is the final one
  always_comb begin
    w_cur = 4'd0;
    for (int i = 15; i >= 0; i--) if (r_list[i]) w_cur = 4'(i);
  end
  assign w_last = ((r_list & (r_list - 16'd1)) == 16'd0);

  // State register and latched transfer context
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_list    <= '0;
      r_addr    <= '0;
      r_final   <= '0;
      r_rn      <= '0;
      r_is_load <= 1'b0;
      r_wb      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) begin
        r_list    <= i_reg_list;
        r_addr    <= w_first;
        r_final   <= w_final;
        r_rn      <= i_rn;
        r_is_load <= i_is_load;
        r_wb      <= w_wb;
      end else if (r_state == S_XFER) begin
        r_list <= r_list & (r_list - 16'd1);
        r_addr <= r_addr + WORD;
      end
    end
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = (w_cnt == 5'd0) ? S_DONE : S_XFER;
      S_XFER: if (w_last) w_next = r_wb ? S_WB : S_DONE;
      S_WB:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Port drive; everything held at zero while reset is asserted
  always_comb begin
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_ra       = '0;
    o_wa3      = '0;
    o_we3      = 1'b0;
    o_wd3      = '0;
    o_pc_we    = 1'b0;
    o_pc_wd    = '0;
    o_mem_addr = '0;
    o_mem_we   = 1'b0;
    o_mem_wd   = '0;
    if (!i_reset) begin
      case (r_state)
        S_XFER: begin
          o_busy     = 1'b1;
          o_mem_addr = r_addr;
          if (r_is_load) begin
            if (w_cur == 4'd15) begin
              o_pc_we = 1'b1;
              o_pc_wd = i_mem_rd;
            end else begin
              o_we3 = 1'b1;
              o_wa3 = w_cur;
              o_wd3 = i_mem_rd;
            end
          end else begin
            o_ra     = w_cur;
            o_mem_we = 1'b1;
            o_mem_wd = i_rd;
          end
        end
        S_WB: begin
          o_busy = 1'b1;
          o_we3  = 1'b1;
          o_wa3  = r_rn;
          o_wd3  = r_final;
        end
        S_DONE: begin
          o_busy = 1'b1;
          o_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
